// File: rtl/nanov_spi_arbiter_pkg.sv
// Shared types, idle pin levels and default sizing for the nanoV SPI bus arbiter.
package nanov_spi_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANTED,
        ST_ACTIVE,
        ST_GAP
    } arb_state_e;

    localparam logic SEL_IDLE    = 1'b1;
    localparam logic MOSI_IDLE   = 1'b0;
    localparam logic CLK_EN_IDLE = 1'b0;

    localparam int GAP_CYCLES_DEF     = 2;
    localparam int MAX_TXN_CYCLES_DEF = 1024;
    localparam int CNT_W_DEF          = 11;

endpackage

// File: rtl/nanov_spi_arbiter_rr_arb2.sv
// Two-way round-robin picker: one-hot winner plus valid, purely combinational.
module nanov_spi_arbiter_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] win,
    output logic       valid
);

    // Under contention the requester that did not win last time goes first.
    assign win[0] = req[0] & (~req[1] | last);
    assign win[1] = req[1] & (~req[0] | ~last);
    assign valid  = |req;

endmodule

// File: rtl/nanov_spi_arbiter.sv
// Shares one SPI memory bus between two requesters with transaction locking and a deselect gap.
// Optional `ARB_TIMEOUT_EN bounds ACTIVE to MAX_TXN_CYCLES and pulses timeout on forced release.
module nanov_spi_arbiter
    import nanov_spi_arbiter_pkg::*;
#(
    parameter int GAP_CYCLES     = GAP_CYCLES_DEF,
    parameter int MAX_TXN_CYCLES = MAX_TXN_CYCLES_DEF,
    parameter int CNT_W          = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    output logic gnt0,
    input  logic sel0_n,
    input  logic mosi0,
    input  logic clk_en0,
    output logic miso0,
    input  logic req1,
    output logic gnt1,
    input  logic sel1_n,
    input  logic mosi1,
    input  logic clk_en1,
    output logic miso1,
    output logic spi_select,
    output logic spi_mosi,
    output logic spi_clk_enable,
    input  logic spi_miso,
    output logic busy,
    output logic owner,
    output logic timeout
);

    arb_state_e state;
    logic [3:0] gap_cnt;
    logic [1:0] win;
    logic       win_vld;
    logic       g_req;
    logic       g_sel_n;
    logic       g_mosi;
    logic       g_clk_en;
    logic       txn_expired;

    nanov_spi_arbiter_rr_arb2 u_rr (
        .req   ({req1, req0}),
        .last  (owner),
        .win   (win),
        .valid (win_vld)
    );

    // While a grant is held, owner names the grantee, so it steers the input mux.
    assign g_req    = owner ? req1    : req0;
    assign g_sel_n  = owner ? sel1_n  : sel0_n;
    assign g_mosi   = owner ? mosi1   : mosi0;
    assign g_clk_en = owner ? clk_en1 : clk_en0;

    assign miso0 = (owner == 1'b0) ? spi_miso : 1'b0;
    assign miso1 = (owner == 1'b1) ? spi_miso : 1'b0;
    assign busy  = (state != ST_IDLE);

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] txn_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txn_cnt <= '0;
        end else if (state == ST_ACTIVE) begin
            txn_cnt <= txn_cnt + 1'b1;
        end else begin
            txn_cnt <= '0;
        end
    end

    assign txn_expired = (txn_cnt == CNT_W'(MAX_TXN_CYCLES - 1));
`else
    // Unbounded transactions; the limit parameters are referenced only to keep them declared-and-used.
    assign txn_expired = (MAX_TXN_CYCLES < 0) && (CNT_W < 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            gnt0           <= 1'b0;
            gnt1           <= 1'b0;
            owner          <= 1'b1;
            timeout        <= 1'b0;
            gap_cnt        <= '0;
            spi_select     <= SEL_IDLE;
            spi_mosi       <= MOSI_IDLE;
            spi_clk_enable <= CLK_EN_IDLE;
        end else begin
            timeout <= 1'b0;

            if (state == ST_GRANTED || state == ST_ACTIVE) begin
                spi_select     <= g_sel_n;
                spi_mosi       <= g_mosi;
                spi_clk_enable <= g_clk_en;
            end else begin
                spi_select     <= SEL_IDLE;
                spi_mosi       <= MOSI_IDLE;
                spi_clk_enable <= CLK_EN_IDLE;
            end

            case (state)
                ST_IDLE: begin
                    if (win_vld) begin
                        state <= ST_GRANTED;
                        owner <= win[1];
                        gnt0  <= win[0];
                        gnt1  <= win[1];
                    end
                end
                ST_GRANTED: begin
                    // Dropping req before select ever fell needs no deselect gap.
                    if (!g_sel_n) begin
                        state <= ST_ACTIVE;
                    end else if (!g_req) begin
                        state <= ST_IDLE;
                        gnt0  <= 1'b0;
                        gnt1  <= 1'b0;
                    end
                end
                ST_ACTIVE: begin
                    if (g_sel_n) begin
                        state <= ST_GAP;
                        gnt0  <= 1'b0;
                        gnt1  <= 1'b0;
                    end else if (txn_expired) begin
                        state          <= ST_GAP;
                        gnt0           <= 1'b0;
                        gnt1           <= 1'b0;
                        timeout        <= 1'b1;
                        spi_select     <= SEL_IDLE;
                        spi_clk_enable <= CLK_EN_IDLE;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == 4'(GAP_CYCLES - 1)) begin
                        gap_cnt <= '0;
                        state   <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nanov_spi_arbiter.sv
// Scoreboard bench for nanov_spi_arbiter: a timestamp-based bus model predicts grants and pin levels.
module tb_nanov_spi_arbiter;

    localparam int GAP = 2;
    localparam int MAX = 16;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] req = 2'b00;
    logic [1:0] sel_n = 2'b11;
    logic [1:0] mosi = 2'b00;
    logic [1:0] clk_en = 2'b00;
    logic       spi_miso = 1'b0;
    logic       gnt0, gnt1, miso0, miso1;
    logic       spi_select, spi_mosi, spi_clk_enable, busy, owner, timeout;

    nanov_spi_arbiter #(
        .GAP_CYCLES     (GAP),
        .MAX_TXN_CYCLES (MAX),
        .CNT_W          (5)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req0           (req[0]),
        .gnt0           (gnt0),
        .sel0_n         (sel_n[0]),
        .mosi0          (mosi[0]),
        .clk_en0        (clk_en[0]),
        .miso0          (miso0),
        .req1           (req[1]),
        .gnt1           (gnt1),
        .sel1_n         (sel_n[1]),
        .mosi1          (mosi[1]),
        .clk_en1        (clk_en[1]),
        .miso1          (miso1),
        .spi_select     (spi_select),
        .spi_mosi       (spi_mosi),
        .spi_clk_enable (spi_clk_enable),
        .spi_miso       (spi_miso),
        .busy           (busy),
        .owner          (owner),
        .timeout        (timeout)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        int cyc;
        bit who;
    } gev_t;

    gev_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n = 0;
    int   to_seen = 0;

    // Reference model: who holds the bus, whether select has fallen, and when the bus is next free.
    int m_holder = -1;
    bit m_started = 1'b0;
    int m_len = 0;
    int m_free_at = 0;
    bit m_owner = 1'b1;
    bit e_sel = 1'b1, e_mosi = 1'b0, e_clk = 1'b0, e_to = 1'b0, e_busy = 1'b0;

    function automatic void check(string name, logic [15:0] act, logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, n);
        end
    endfunction

    function automatic logic gnt_of(int idx);
        return (idx == 1) ? gnt1 : gnt0;
    endfunction

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_holder = -1; m_started = 1'b0; m_len = 0; m_free_at = 0; m_owner = 1'b1;
            e_sel = 1'b1; e_mosi = 1'b0; e_clk = 1'b0; e_to = 1'b0; e_busy = 1'b0;
        end else begin
            n++;
            e_to = 1'b0;
            if (m_holder >= 0) begin
                e_sel = sel_n[m_holder]; e_mosi = mosi[m_holder]; e_clk = clk_en[m_holder];
            end else begin
                e_sel = 1'b1; e_mosi = 1'b0; e_clk = 1'b0;
            end
            if (m_holder >= 0) begin
                if (!m_started) begin
                    if (!sel_n[m_holder]) begin
                        m_started = 1'b1; m_len = 0;
                    end else if (!req[m_holder]) begin
                        m_holder = -1; m_free_at = n + 1;
                    end
                end else begin
                    m_len++;
                    if (sel_n[m_holder]) begin
                        m_holder = -1; m_free_at = n + GAP + 1;
                    end else if (TO_EN && m_len == MAX) begin
                        m_holder = -1; m_free_at = n + GAP + 1;
                        e_to = 1'b1; e_sel = 1'b1; e_clk = 1'b0;
                    end
                end
            end else if (n >= m_free_at && req != 2'b00) begin
                m_holder = (req == 2'b11) ? int'(!m_owner) : (req[1] ? 1 : 0);
                m_owner = m_holder[0];
                m_started = 1'b0;
                sb_q.push_back('{cyc: n, who: m_holder[0]});
            end
            e_busy = (m_holder >= 0) || (n + 1 < m_free_at);
        end
    end

    // Monitor: compares pins every cycle and pops the grant scoreboard when a grant is due or seen.
    initial begin
        logic [1:0]  prev_g;
        logic        rise;
        logic [15:0] act, exp;
        gev_t        e;
        prev_g = 2'b00;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                prev_g = 2'b00;
                continue;
            end
            act = {6'b0, spi_select, spi_mosi, spi_clk_enable, gnt0, gnt1, busy, owner, timeout, miso0, miso1};
            exp = {6'b0, e_sel, e_mosi, e_clk, m_holder == 0, m_holder == 1, e_busy, m_owner, e_to,
                   (m_owner == 1'b0) ? spi_miso : 1'b0, (m_owner == 1'b1) ? spi_miso : 1'b0};
            check("pins", act, exp);
            rise = (gnt0 && !prev_g[0]) || (gnt1 && !prev_g[1]);
            if (sb_q.size() > 0 && sb_q[0].cyc == n) begin
                e = sb_q.pop_front();
                check("grant", {14'b0, rise, gnt1}, {14'b0, 1'b1, e.who});
            end else if (rise) begin
                check("grant_unexpected", {15'b0, rise}, 16'd0);
            end
            prev_g = {gnt1, gnt0};
            if (timeout === 1'b1) to_seen++;
        end
    end

    initial forever begin
        @(negedge clk);
        spi_miso = 1'($urandom);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_reset_pins(string name);
        check(name, {8'b0, spi_select, spi_mosi, spi_clk_enable, gnt0, gnt1, busy, owner, timeout},
              16'b0000_0000_1000_0010);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1 check_reset_pins("reset_vals");
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic noise(int idx);
        sel_n[idx]  = 1'($urandom);
        mosi[idx]   = 1'($urandom);
        clk_en[idx] = 1'($urandom);
    endtask

    // One requester transaction: request, wait for grant, optional abort, otherwise clock len bits.
    task automatic txn(int idx, int pre, int len, bit abort);
        int waited;
        @(negedge clk);
        req[idx] = 1'b1; sel_n[idx] = 1'b1; mosi[idx] = 1'b0; clk_en[idx] = 1'b0;
        waited = 0;
        forever begin
            @(negedge clk);
            if (gnt_of(idx) === 1'b1) break;
            waited++;
            if (waited > 400) begin
                check("gnt_wait", {15'b0, gnt_of(idx)}, 16'd1);
                req[idx] = 1'b0; sel_n[idx] = 1'b1;
                return;
            end
            noise(idx);
        end
        sel_n[idx] = 1'b1; mosi[idx] = 1'b0; clk_en[idx] = 1'b0;
        repeat (pre) @(negedge clk);
        if (!abort) begin
            sel_n[idx] = 1'b0;
            for (int k = 0; k < len; k++) begin
                @(negedge clk);
                if (gnt_of(idx) !== 1'b1) break;
                mosi[idx]   = 1'($urandom);
                clk_en[idx] = 1'($urandom);
                if ($urandom_range(0, 15) == 0) req[idx] = 1'b0;
            end
            sel_n[idx] = 1'b1; clk_en[idx] = 1'b0;
        end
        req[idx] = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        #1 check_reset_pins("reset_vals");
        @(negedge clk);
        rst = 1'b0;

        txn(0, 0, 40, 1'b0);
        repeat (6) @(negedge clk);

        do_reset();
        fork
            txn(0, 1, 10, 1'b0);
            txn(1, 1, 10, 1'b0);
        join
        repeat (6) @(negedge clk);

        fork
            txn(1, 2, 30, 1'b0);
            begin
                repeat (15) begin @(negedge clk); noise(0); end
                txn(0, 0, 8, 1'b0);
            end
        join
        repeat (6) @(negedge clk);

        fork
            txn(0, 2, 0, 1'b1);
            begin @(negedge clk); txn(1, 0, 5, 1'b0); end
        join
        repeat (6) @(negedge clk);

        fork
            txn(0, 0, 30, 1'b0);
            begin
                repeat (10) @(negedge clk);
                @(posedge clk);
                #3 rst = 1'b1;
                #2 check_reset_pins("async_reset");
                #3 rst = 1'b0;
            end
        join
        repeat (6) @(negedge clk);

        to_seen = 0;
        fork
            txn(0, 0, 40, 1'b0);
            begin repeat (5) @(negedge clk); txn(1, 0, 5, 1'b0); end
        join
        repeat (6) @(negedge clk);
        check("timeout_count", 16'(to_seen), 16'(TO_EN));

        fork
            for (int k = 0; k < 25; k++) begin
                repeat ($urandom_range(0, 4)) begin @(negedge clk); noise(0); end
                txn(0, $urandom_range(0, 3), $urandom_range(1, 24), $urandom_range(0, 5) == 0);
            end
            for (int j = 0; j < 25; j++) begin
                repeat ($urandom_range(0, 4)) begin @(negedge clk); noise(1); end
                txn(1, $urandom_range(0, 3), $urandom_range(1, 24), $urandom_range(0, 5) == 0);
            end
        join

        repeat (30) @(negedge clk);
        check("sb_drain", 16'(sb_q.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
